// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, issues one instruction fetch at a time over a
// req/gnt/rvalid handshake, holds the fetched word for execute, and selects
// the next PC (sequential, JAL, JALR or taken branch) when execute accepts it.
// A misaligned next PC parks the unit in HALT until reset.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] Instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [31:0] rs1Data,
  input  logic        Branch,
  output logic        misaligned,
  output logic [31:0] retired
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;

  // I-type immediate from instruction bits [31:20].
  function automatic logic [31:0] imm_i(input logic [11:0] raw);
    return {{20{raw[11]}}, raw};
  endfunction

  // B-type immediate from bits [31:25] (hi) and [11:7] (lo); LSB is always 0.
  function automatic logic [31:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

  // J-type immediate from bits [31:12]; LSB is always 0.
  function automatic logic [31:0] imm_j(input logic [19:0] raw);
    return {{12{raw[19]}}, raw[7:0], raw[8], raw[18:9], 1'b0};
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic [31:0] pc_r;
  logic [31:0] insn_r;
  logic [31:0] retired_r;
  logic [31:0] target_s;
  logic        req_r;
  logic        valid_r;
  logic        misaligned_r;
  logic        accept_s;
  logic        target_bad_s;

  // Candidate next PC for the held instruction, using the live Branch and rs1Data.
  always_comb begin
    target_s = pc_r + 32'd4;
    case (insn_r[6:0])
      OP_JAL:  target_s = pc_r + imm_j(insn_r[31:12]);
      OP_JALR: target_s = (rs1Data + imm_i(insn_r[31:20])) & 32'hFFFF_FFFE;
      OP_BRANCH: begin
        if (Branch) begin
          target_s = pc_r + imm_b(insn_r[31:25], insn_r[11:7]);
        end else begin
          target_s = pc_r + 32'd4;
        end
      end
      default: target_s = pc_r + 32'd4;
    endcase
  end

  assign accept_s     = (state_r == ST_HOLD) && inst_ready;
  assign target_bad_s = (target_s[1:0] != 2'b00);

  // Fetch sequencing: one outstanding request, hold until execute accepts.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          if (target_bad_s) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus registered request/valid flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      req_r   <= (state_s == ST_REQ);
      valid_r <= (state_s == ST_HOLD);
    end
  end

  // PC, held instruction word, sticky misalignment trap and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_PC;
      insn_r       <= NOP_INSN;
      misaligned_r <= 1'b0;
      retired_r    <= 32'd0;
    end else begin
      if ((state_r == ST_WAIT) && imem_rvalid) begin
        insn_r <= imem_rdata;
      end else if (accept_s) begin
        insn_r <= NOP_INSN;
      end
      if (accept_s && !target_bad_s) begin
        pc_r      <= target_s;
        retired_r <= retired_r + 32'd1;
      end
      if (accept_s && target_bad_s) begin
        misaligned_r <= 1'b1;
      end
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign inst_valid  = valid_r;
  assign Instruction = insn_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_r + 32'd4;
  assign misaligned  = misaligned_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: drives a randomized instruction memory and execute stage,
// predicts fetch addresses and held instructions from the RV32I control-flow
// rules, and checks them in a monitor that pops a scoreboard.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int K_ALU  = 0;
  localparam int K_BR   = 1;
  localparam int K_JAL  = 2;
  localparam int K_JALR = 3;

  typedef struct {
    logic [31:0] insn;
    int          kind;
    logic [31:0] off;
    bit          br;
    logic [31:0] rs1;
    int          gd;
    int          vd;
    int          rd;
    bit          spur;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] Instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] rs1Data = 32'd0;
  logic        Branch = 1'b0;
  logic        misaligned;
  logic [31:0] retired;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .Instruction(Instruction), .pc(pc), .pc_plus4(pc_plus4),
    .rs1Data(rs1Data), .Branch(Branch),
    .misaligned(misaligned), .retired(retired)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] addr_q[$];
  logic [63:0] hold_q[$];
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_ret = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Encoders: place an intended offset into the RV32I bit fields.
  function automatic logic [31:0] enc_i(input logic [31:0] o, input logic [6:0] opc);
    logic [4:0] r1;
    logic [4:0] rdst;
    r1 = 5'($urandom);
    rdst = 5'($urandom);
    return {o[11:0], r1, 3'b000, rdst, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] o, input logic [2:0] f3);
    logic [4:0] r1;
    logic [4:0] r2;
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    return {o[12], o[10:5], r2, r1, f3, o[4:1], o[11], 7'b110_0011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] o);
    logic [4:0] rdst;
    rdst = 5'($urandom);
    return {o[20], o[10:1], o[11], o[19:12], rdst, 7'b110_1111};
  endfunction

  function automatic txn_t mk(input int kind, input logic [31:0] off, input bit br,
                              input logic [31:0] rs1, input int gd, input int vd,
                              input int rd, input bit spur);
    txn_t t;
    logic [6:0] alu_ops [4];
    alu_ops[0] = 7'b001_0011;
    alu_ops[1] = 7'b011_0011;
    alu_ops[2] = 7'b011_0111;
    alu_ops[3] = 7'b000_0011;
    t.kind = kind; t.off = off; t.br = br; t.rs1 = rs1;
    t.gd = gd; t.vd = vd; t.rd = rd; t.spur = spur;
    case (kind)
      K_BR:    t.insn = enc_b(off, (br ? 3'b000 : 3'b001));
      K_JAL:   t.insn = enc_j(off);
      K_JALR:  t.insn = enc_i(off, 7'b110_0111);
      default: t.insn = spur ? enc_i(off, alu_ops[$urandom_range(0, 3)]) : enc_i(off, 7'b001_0011);
    endcase
    return t;
  endfunction

  // Reference next PC from the control-flow rules and the intended offset.
  function automatic logic [31:0] model_next(input txn_t t, input logic [31:0] p);
    case (t.kind)
      K_JAL:   return p + t.off;
      K_JALR:  return (t.rs1 + t.off) & ~32'd1;
      K_BR:    return t.br ? p + t.off : p + 32'd4;
      default: return p + 32'd4;
    endcase
  endfunction

  function automatic txn_t rand_txn();
    int k;
    int v;
    logic [31:0] off;
    logic [31:0] rs1;
    k = $urandom_range(0, 9);
    rs1 = $urandom;
    if (k <= 3) begin
      off = $urandom;
      return mk(K_ALU, off, 1'($urandom), rs1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    end else if (k <= 6) begin
      v = int'($urandom_range(0, 511)) - 256;
      off = 32'(v * 4);
      if ($urandom_range(0, 14) == 0) off = off + 32'd2;
      return mk(K_BR, off, 1'($urandom), rs1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    end else if (k <= 8) begin
      v = int'($urandom_range(0, 65535)) - 32768;
      off = 32'(v * 4);
      if ($urandom_range(0, 14) == 0) off = off + 32'd2;
      return mk(K_JAL, off, 1'($urandom), rs1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    end else begin
      v = int'($urandom_range(0, 1023)) - 512;
      off = 32'(v * 4) + 32'($urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0) rs1 = rs1 & ~32'd3;
      return mk(K_JALR, off, 1'($urandom), rs1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    end
  endfunction

  task automatic noise(input bit en);
    imem_gnt    = en ? ($urandom_range(0, 3) == 0) : 1'b0;
    imem_rvalid = en ? ($urandom_range(0, 3) == 0) : 1'b0;
    imem_rdata  = $urandom;
    inst_ready  = en ? ($urandom_range(0, 3) == 0) : 1'b0;
    Branch      = en ? 1'($urandom) : 1'b0;
    rs1Data     = $urandom;
  endtask

  task automatic check_reset_vals();
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
    chk("rst_instruction", Instruction, NOP);
  endtask

  // Called at a negedge: asserts reset between edges, checks it took effect
  // before any clock edge, and releases it on the following negedge.
  task automatic reset_dut();
    #2;
    rst_n = 1'b0;
    noise(1'b0);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    addr_q.delete();
    hold_q.delete();
    m_pc = RST_PC;
    m_ret = 32'd0;
    addr_q.push_back(RST_PC);
  endtask

  task automatic wait_req(input bit en, output bit ok);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      noise(en);
      @(negedge clk);
      n++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) note_fail("req_timeout");
  endtask

  task automatic do_fetch(input txn_t t, output bit halted);
    logic [31:0] nxt;
    bit ok;
    halted = 1'b0;
    wait_req(t.spur, ok);
    if (!ok) begin
      halted = 1'b1;
      return;
    end
    for (int i = 0; i < t.gd; i++) begin
      noise(t.spur); imem_gnt = 1'b0;
      @(negedge clk);
    end
    noise(t.spur); imem_gnt = 1'b1;
    @(negedge clk);
    chk("req_low_in_wait", {31'd0, imem_req}, 32'd0);
    chk("valid_low_in_wait", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < t.vd; i++) begin
      noise(t.spur); imem_rvalid = 1'b0;
      @(negedge clk);
    end
    noise(t.spur); imem_rvalid = 1'b1; imem_rdata = t.insn;
    hold_q.push_back({m_pc, t.insn});
    @(negedge clk);
    for (int i = 0; i < t.rd; i++) begin
      noise(t.spur); inst_ready = 1'b0;
      @(negedge clk);
    end
    noise(t.spur); inst_ready = 1'b1; Branch = t.br; rs1Data = t.rs1;
    nxt = model_next(t, m_pc);
    if (nxt[1:0] == 2'b00) begin
      m_pc = nxt;
      m_ret = m_ret + 32'd1;
      addr_q.push_back(nxt);
    end
    @(negedge clk);
    noise(1'b0);
    if (nxt[1:0] != 2'b00) begin
      for (int c = 0; c < 3; c++) begin
        chk("halt_misaligned", {31'd0, misaligned}, 32'd1);
        chk("halt_pc", pc, m_pc);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_valid", {31'd0, inst_valid}, 32'd0);
        chk("halt_retired", retired, m_ret);
        chk("halt_instruction", Instruction, NOP);
        noise(t.spur);
        @(negedge clk);
      end
      noise(1'b0);
      halted = 1'b1;
    end else begin
      chk("retired", retired, m_ret);
      chk("misaligned_clear", {31'd0, misaligned}, 32'd0);
    end
  endtask

  // Scoreboard monitor: pops an expected address on each new request and an
  // expected instruction/pc on each new valid, and checks them every cycle held.
  logic        mon_pr = 1'b0;
  logic        mon_pv = 1'b0;
  logic [31:0] mon_addr = 32'd0;
  logic [63:0] mon_hold = 64'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pr = 1'b0;
      mon_pv = 1'b0;
    end else begin
      if (imem_req === 1'b1) begin
        if (!mon_pr) begin
          if (addr_q.size() == 0) note_fail("unexpected_request");
          else mon_addr = addr_q.pop_front();
        end
        chk("imem_addr", imem_addr, mon_addr);
        chk("pc_in_req", pc, mon_addr);
        chk("valid_low_in_req", {31'd0, inst_valid}, 32'd0);
      end
      if (inst_valid === 1'b1) begin
        if (!mon_pv) begin
          if (hold_q.size() == 0) note_fail("unexpected_valid");
          else mon_hold = hold_q.pop_front();
        end
        chk("instruction", Instruction, mon_hold[31:0]);
        chk("pc_in_hold", pc, mon_hold[63:32]);
        chk("pc_plus4", pc_plus4, mon_hold[63:32] + 32'd4);
      end
      mon_pr = imem_req;
      mon_pv = inst_valid;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    @(negedge clk);
    reset_dut();
    // Sequential fetch with zero wait states, then branch/jump targets.
    do_fetch(mk(K_ALU, 32'h0000_0001, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_ALU, 32'h0000_0002, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_JAL, 32'h0000_00F8, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_BR, 32'hFFFF_FFF8, 1'b1, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_JAL, 32'h0000_0008, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_BR, 32'hFFFF_FFF8, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_JAL, 32'hFFFF_FE3C, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_JAL, 32'h0000_0800, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_JALR, 32'h0000_0002, 1'b0, 32'h0000_1003, 0, 0, 0, 1'b0), h);
    // Stalls: gnt late by 3, rvalid 2 after gnt, ready late by 4, with noise.
    do_fetch(mk(K_ALU, 32'h0000_0005, 1'b0, 32'd0, 3, 1, 4, 1'b1), h);
    chk("pc_after_stall", pc, 32'h0000_1008);
    // Taken branch to +6 traps.
    do_fetch(mk(K_BR, 32'h0000_0006, 1'b1, 32'd0, 0, 0, 0, 1'b0), h);
    reset_dut();
    // Async reset in WAIT, with a late rvalid arriving after release.
    do_fetch(mk(K_ALU, 32'h0000_0007, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_ALU, 32'h0000_0008, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    wait_req(1'b0, h);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    reset_dut();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0040_0093;
    @(negedge clk);
    chk("first_req_second_cycle", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("late_rvalid_ignored", Instruction, NOP);
    chk("late_rvalid_no_valid", {31'd0, inst_valid}, 32'd0);
    // PC wraps through 0xFFFF_FFFC.
    do_fetch(mk(K_ALU, 32'h0000_0009, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_JALR, 32'h0000_0004, 1'b0, 32'hFFFF_FFF8, 0, 0, 0, 1'b0), h);
    do_fetch(mk(K_ALU, 32'h0000_000A, 1'b0, 32'd0, 0, 0, 0, 1'b0), h);
    chk("pc_wrapped", pc, 32'h0000_0000);
    // Randomized traffic; any trap is followed by a reset.
    for (int n = 0; n < 300; n++) begin
      do_fetch(rand_txn(), h);
      if (h) reset_dut();
    end
    @(negedge clk);
    chk("queues_drained", 32'(addr_q.size() + hold_q.size()), (imem_req === 1'b1) ? 32'd0 : 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
